// File: rtl/div_iter_32_pkg.sv
// Shared constants and state encoding for the iterative signed divider.
package div_iter_32_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam int unsigned ITER_LAST = DIV_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_32_if.sv
// Start/ready handshake and operand/result bus shared with the multiplier.
interface div_iter_32_if #(
  parameter int unsigned WIDTH = div_iter_32_pkg::DIV_WIDTH
);

  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/div_iter_32_div_counter.sv
// Iteration counter; term_o flags the final iteration while counting.
module div_iter_32_div_counter
  import div_iter_32_pkg::*;
#(
  parameter int unsigned CNT_W = DIV_CNT_W,
  parameter int unsigned LAST  = ITER_LAST
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr || clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign term_o = en_i && (cnt_q == CNT_W'(LAST - 1));

endmodule

// File: rtl/div_iter_32.sv
// Iterative signed restoring divider: one quotient bit per cycle on magnitudes,
// sign applied when the result is registered.
module div_iter_32
  import div_iter_32_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input logic         clk,
  input logic         clr,
  div_iter_32_if.slave bus
);

  div_state_e       state_q;
  logic [WIDTH-1:0] absb_q;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             sign_q;
  logic             dbz_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;

  logic [WIDTH+1:0] shifted, trial;
  logic             quo_bit;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             last_iter;

  div_iter_32_div_counter #(
    .CNT_W (CNT_W),
    .LAST  (WIDTH)
  ) u_counter (
    .clk     (clk),
    .clr     (clr),
    .clear_i (bus.ctrl_div),
    .en_i    ((state_q == S_RUN) && !bus.ctrl_div),
    .term_o  (last_iter)
  );

  // |-2^(W-1)| wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    abs_a   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    abs_b   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {2'b00, absb_q};
    quo_bit = ~trial[WIDTH+1];
    rem_d   = quo_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    quo_d   = {quo_q[WIDTH-2:0], quo_bit};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      absb_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sign_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_div) begin
        // A new start aborts whatever is in flight.
        quo_q   <= abs_a;
        absb_q  <= abs_b;
        rem_q   <= '0;
        sign_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        dbz_q   <= (bus.data_operandB == '0);
        exc_q   <= 1'b0;
        state_q <= (bus.data_operandB == '0) ? S_DONE : S_RUN;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (last_iter) state_q <= S_DONE;
          end
          S_DONE: begin
            result_q <= dbz_q ? '0 : (sign_q ? -quo_q : quo_q);
            exc_q    <= dbz_q;
            rdy_q    <= 1'b1;
            state_q  <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div_iter_32.sv
// Self-checking bench for div_iter_32: vector table, random ops vs. an
// arithmetic model, and abort/reset corner sequences.
module tb_div_iter_32;
  import div_iter_32_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  div_iter_32_if bus_if ();

  div_iter_32 dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint la, lb, q;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = la / lb;
      r = q[31:0];
      e = 1'b0;
    end
  endfunction

  // Pulse ctrl_div for one edge (E0); returns at E0 + 1.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus_if.ctrl_div      = 1'b1;
    bus_if.data_operandA = a;
    bus_if.data_operandB = b;
    @(posedge clk);
    #1;
    bus_if.ctrl_div      = 1'b0;
    bus_if.data_operandA = $urandom;
    bus_if.data_operandB = $urandom;
  endtask

  // Observe a bounded window; lat is the edge index of the first RDY pulse.
  task automatic watch(input int cycles, output int lat, output int pulses,
                       output logic [31:0] r, output logic e);
    lat = -1;
    pulses = 0;
    r = '0;
    e = 1'b0;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.data_resultRDY === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          r = bus_if.data_result;
          e = bus_if.data_exception;
        end
      end
    end
  endtask

  int          lat, pulses;
  logic [31:0] r, mr;
  logic        e, me;

  initial begin
    vecs[0] = '{32'd100,      32'd7,        32'd14,       1'b0};
    vecs[1] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
    vecs[2] = '{32'd7,        32'hFFFFFF9C, 32'd0,        1'b0};
    vecs[3] = '{32'd5,        32'd0,        32'd0,        1'b1};
    vecs[4] = '{32'd9,        32'd3,        32'd3,        1'b0};
    vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[6] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[7] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[9] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0};

    bus_if.ctrl_div      = 1'b0;
    bus_if.data_operandA = '0;
    bus_if.data_operandB = '0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    chk("reset_result", bus_if.data_result, 32'd0);
    chk("reset_exc", {31'd0, bus_if.data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, bus_if.data_resultRDY}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      start(vecs[i].a, vecs[i].b);
      watch(40, lat, pulses, r, e);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_exc", i), {31'd0, e}, {31'd0, vecs[i].exc});
      chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].exc ? 32'd1 : 32'd33);
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'd1);
      chk($sformatf("vec%0d_hold", i), bus_if.data_result, vecs[i].res);
    end

    // Exception is cleared at start, before the new result arrives.
    start(32'd5, 32'd0);
    watch(5, lat, pulses, r, e);
    start(32'd9, 32'd3);
    chk("exc_clear_at_start", {31'd0, bus_if.data_exception}, 32'd0);
    watch(40, lat, pulses, r, e);
    chk("after_dbz_result", r, 32'd3);
    chk("after_dbz_latency", 32'(lat), 32'd33);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      if (i % 4 == 1) a = 32'($signed($urandom_range(0, 2000)) - 1000);
      model(a, b, mr, me);
      start(a, b);
      watch(40, lat, pulses, r, e);
      chk($sformatf("rand%0d_result", i), r, mr);
      chk($sformatf("rand%0d_exc", i), {31'd0, e}, {31'd0, me});
      chk($sformatf("rand%0d_latency", i), 32'(lat), me ? 32'd1 : 32'd33);
    end

    // Abort: restart at cycle 10 of a running op.
    start(32'd100, 32'd7);
    watch(10, lat, pulses, r, e);
    chk("abort_no_early_rdy", 32'(pulses), 32'd0);
    start(32'd9, 32'd3);
    watch(45, lat, pulses, r, e);
    chk("abort_result", r, 32'd3);
    chk("abort_latency", 32'(lat), 32'd33);
    chk("abort_pulses", 32'(pulses), 32'd1);

    // ctrl_div held for three edges; last operands win.
    bus_if.ctrl_div = 1'b1;
    bus_if.data_operandA = 32'd50;
    bus_if.data_operandB = 32'd5;
    @(posedge clk); #1;
    bus_if.data_operandA = 32'd1000;
    bus_if.data_operandB = 32'd10;
    @(posedge clk); #1;
    start(32'd27, 32'd4);
    watch(40, lat, pulses, r, e);
    chk("held_result", r, 32'd6);
    chk("held_latency", 32'(lat), 32'd33);
    chk("held_pulses", 32'(pulses), 32'd1);

    // clr mid-operation kills it and zeroes outputs.
    start(32'd100, 32'd7);
    watch(20, lat, pulses, r, e);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    watch(40, lat, pulses, r, e);
    chk("clr_mid_pulses", 32'(pulses), 32'd0);
    chk("clr_mid_result", bus_if.data_result, 32'd0);
    chk("clr_mid_exc", {31'd0, bus_if.data_exception}, 32'd0);

    // clr wins over a simultaneous start.
    clr = 1'b1;
    bus_if.ctrl_div = 1'b1;
    bus_if.data_operandA = 32'd100;
    bus_if.data_operandB = 32'd7;
    @(posedge clk); #1;
    clr = 1'b0;
    bus_if.ctrl_div = 1'b0;
    watch(40, lat, pulses, r, e);
    chk("clr_start_pulses", 32'(pulses), 32'd0);
    chk("clr_start_result", bus_if.data_result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter_32.md
Name: div_iter_32

Overview:
Iterative 32-bit signed restoring divider for the multdiv unit. It consumes the operands held in the divider operand registers and produces one quotient bit per cycle. It returns the quotient with a one-cycle ready pulse and a divide-by-zero exception flag. It sits beside the multiplier and shares the start/ready handshake with it.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 verified)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous active-high reset
ctrl_div  input  1  start pulse; operands sampled on the same edge
data_operandA  input  WIDTH  dividend, two's complement
data_operandB  input  WIDTH  divisor, two's complement
data_result  output  WIDTH  quotient, truncated toward zero
data_exception  output  1  high when the last operation divided by zero
data_resultRDY  output  1  one-cycle pulse: result/exception valid

Behaviour:
- Reset:
  - clr sampled high at an edge -> state IDLE, counter 0, internal regs 0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - clr has priority over ctrl_div in the same cycle.
- States: IDLE, RUN, DONE.
  - IDLE: waits; outputs hold their last values.
  - RUN: one iteration per edge.
  - DONE: single cycle; registers the signed result, pulses RDY, then returns to IDLE.
- Start, ctrl_div high at edge E0 in any state:
  - latch |A|, |B| (WIDTH-bit unsigned; |-2^31| = 0x80000000 is representable);
  - latch sign = A[msb] XOR B[msb];
  - clear remainder (WIDTH+1 bits) and counter; clear data_exception; go to RUN.
- Divide by zero (B==0 at E0):
  - skip RUN and go directly to DONE;
  - at E1: data_result=0, data_exception=1, RDY high in the cycle after E1.
- RUN iteration, edges E1..E32:
  - shift {rem,quo} left by 1;
  - trial = rem - |B|; if trial is non-negative, rem=trial and quo[0]=1, else quo[0]=0;
  - counter++; after iteration WIDTH (counter==WIDTH) go to DONE.
- DONE (edge E33):
  - data_result = sign ? -quo : quo (mod 2^WIDTH);
  - data_exception=0; data_resultRDY=1 for exactly the cycle after E33.
- Latency: 33 edges from ctrl_div to result registered (1 edge for divide by zero).
- Output hold: data_result and data_exception hold until the next DONE or clr; RDY is low otherwise.
- ctrl_div during RUN or DONE: abort the current operation, restart with the new operands; no RDY for the aborted one.
- ctrl_div held high for multiple cycles: each edge restarts; the operation runs from the last high edge.
- Overflow: -2^31 / -1 -> 0x80000000 (wraps), data_exception=0.
- Remainder: not output.
- Operand inputs: may change freely after E0.

Decomposition:
- Shared package:
  - WIDTH default;
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - ITER_LAST = WIDTH.
- One sub-module: div_counter (CNT_W-bit up-counter with synchronous clear and enable; output terminal flag when count==ITER_LAST-1 and enabled).
- Datapath registers are instantiated as the existing enable/clear flip-flop register.

Test Plan:
- clr, then A=100, B=7 pulse -> RDY exactly 33 cycles later, result=14, exception=0; RDY low the next cycle.
- A=-100 (0xFFFFFF9C), B=7 -> result 0xFFFFFFF2 (-14); A=7, B=-100 -> result 0.
- A=5, B=0 -> RDY one cycle after start, result 0, exception 1; next op 9/3 -> exception 0, result 3.
- A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 0; A=0x80000000, B=1 -> 0x80000000.
- Start 100/7, then at cycle 10 start 9/3 -> single RDY 33 cycles after second start, result 3.
- Start 100/7, clr at cycle 20 -> no RDY ever, outputs 0; clr and ctrl_div in the same cycle -> stays IDLE.
